// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt entry/return controller.
package int_ctrl_pkg;

  localparam int FLAG_W = 4;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_IVT = 2'b01;
  localparam logic [1:0] PCSEL_RET = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_PC,
    S_PUSH_FLAGS,
    S_VECTOR,
    S_SERVICE,
    S_POP_FLAGS,
    S_POP_PC,
    S_RESUME
  } state_t;

endpackage

// File: rtl/int_ctrl_edge_det.sv
// Registers an async-ish level input and pulses for one cycle on its registered rising edge.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sigIn,
  output logic rise
);

  logic syncQ;
  logic syncD;

  always_ff @(posedge clk) begin
    if (!rst) begin
      syncQ <= 1'b0;
      syncD <= 1'b0;
    end else begin
      syncQ <= sigIn;
      syncD <= syncQ;
    end
  end

  assign rise = syncQ & ~syncD;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: drains the pipe, pushes PC/flags, vectors, and unwinds on RTI.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int PC_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_req,
  input  logic              stall,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              rti_dec,
  input  logic [PC_W-1:0]   mem_rdata,
  output logic              fetch_hold,
  output logic              stack_push,
  output logic              stack_pop,
  output logic              stack_en32,
  output logic [PC_W-1:0]   stack_wdata,
  output logic [1:0]        pc_sel,
  output logic [PC_W-1:0]   ret_pc,
  output logic              flags_restore,
  output logic [FLAG_W-1:0] flags_out,
  output logic              int_active
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t            state, nextState;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              pending;
  logic              reqRise;
  logic [PC_W-1:0]   savedPc;
  logic [FLAG_W-1:0] savedFlags;
  logic              takeInt;

  edge_det uEdge (
    .clk   (clk),
    .rst   (rst),
    .sigIn (int_req),
    .rise  (reqRise)
  );

  assign takeInt = (state == S_IDLE) && pending && !stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      savedPc    <= '0;
      savedFlags <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
      // A fresh edge wins over the VECTOR clear so it is not lost.
      if (reqRise)
        pending <= 1'b1;
      else if (state == S_VECTOR && !stall)
        pending <= 1'b0;
      if (takeInt) begin
        savedPc    <= pc_in;
        savedFlags <= flags_in;
      end
    end
  end

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    if (!stall) begin
      case (state)
        S_IDLE: begin
          if (pending) begin
            nextState = S_DRAIN;
            cntNext   = CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        S_DRAIN: begin
          if (cnt == '0) nextState = S_PUSH_PC;
          else           cntNext   = cnt - 1'b1;
        end
        S_PUSH_PC:    nextState = S_PUSH_FLAGS;
        S_PUSH_FLAGS: nextState = S_VECTOR;
        S_VECTOR:     nextState = S_SERVICE;
        S_SERVICE:    if (rti_dec) nextState = S_POP_FLAGS;
        S_POP_FLAGS:  nextState = S_POP_PC;
        S_POP_PC:     nextState = S_RESUME;
        S_RESUME:     nextState = S_IDLE;
        default:      nextState = S_IDLE;
      endcase
    end
  end

  // Pure state decodes; strobes are masked while the pipe is stalled.
  always_comb begin
    fetch_hold    = 1'b0;
    stack_push    = 1'b0;
    stack_pop     = 1'b0;
    stack_en32    = 1'b0;
    stack_wdata   = '0;
    pc_sel        = PCSEL_SEQ;
    ret_pc        = '0;
    flags_restore = 1'b0;
    flags_out     = '0;
    int_active    = (state != S_IDLE);
    case (state)
      S_DRAIN: fetch_hold = 1'b1;
      S_PUSH_PC: begin
        stack_push  = !stall;
        stack_en32  = 1'b1;
        stack_wdata = savedPc;
      end
      S_PUSH_FLAGS: begin
        stack_push  = !stall;
        stack_wdata = PC_W'(savedFlags);
      end
      S_VECTOR: pc_sel = stall ? PCSEL_SEQ : PCSEL_IVT;
      S_POP_FLAGS: begin
        stack_pop  = !stall;
        fetch_hold = 1'b1;
      end
      S_POP_PC: begin
        stack_pop     = !stall;
        stack_en32    = 1'b1;
        fetch_hold    = 1'b1;
        flags_restore = !stall;
        flags_out     = mem_rdata[FLAG_W-1:0];
      end
      S_RESUME: begin
        pc_sel = stall ? PCSEL_SEQ : PCSEL_RET;
        ret_pc = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench: tests queue cycle-stamped expectations, a negedge monitor checks them.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        int_req = 1'b0;
  logic        stall = 1'b0;
  logic        rti_dec = 1'b0;
  logic [31:0] pc_in = '0;
  logic [3:0]  flags_in = '0;
  logic [31:0] mem_rdata = '0;
  logic        fetch_hold, stack_push, stack_pop, stack_en32, flags_restore, int_active;
  logic [31:0] stack_wdata, ret_pc;
  logic [1:0]  pc_sel;
  logic [3:0]  flags_out;

  int_ctrl #(.DRAIN_CYCLES(3), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .stall(stall), .pc_in(pc_in),
    .flags_in(flags_in), .rti_dec(rti_dec), .mem_rdata(mem_rdata),
    .fetch_hold(fetch_hold), .stack_push(stack_push), .stack_pop(stack_pop),
    .stack_en32(stack_en32), .stack_wdata(stack_wdata), .pc_sel(pc_sel),
    .ret_pc(ret_pc), .flags_restore(flags_restore), .flags_out(flags_out),
    .int_active(int_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          c;
    logic        push, pop, en32;
    logic [31:0] wdata;
    logic [1:0]  sel;
    logic [31:0] ret;
    logic        fr;
    logic [3:0]  fo;
  } ev_t;

  typedef struct packed {
    int   c;
    logic fh, act, zero;
  } lv_t;

  ev_t evQ[$];
  lv_t lvQ[$];
  int  nVec = 0;
  int  nErr = 0;
  int  base = 0;

  function automatic ev_t mkEv(int c, logic pu, logic po, logic e32, logic [31:0] wd,
                               logic [1:0] sl, logic [31:0] rt, logic fr, logic [3:0] fo);
    mkEv = '{c, pu, po, e32, wd, sl, rt, fr, fo};
  endfunction

  task automatic expEv(int c, logic pu, logic po, logic e32, logic [31:0] wd,
                       logic [1:0] sl, logic [31:0] rt, logic fr, logic [3:0] fo);
    evQ.push_back(mkEv(base + c, pu, po, e32, wd, sl, rt, fr, fo));
  endtask

  task automatic expLv(int c, logic fh, logic act, logic zero);
    lvQ.push_back('{base + c, fh, act, zero});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(int n);
    while (cyc < base + n) tick();
  endtask

  // Monitor: every strobe cycle must match the next queued event; level checks fire on their cycle.
  always @(negedge clk) begin
    ev_t a, e;
    lv_t l;
    logic [108:0] allOut;
    if ((stack_push | stack_pop | flags_restore | (pc_sel != 2'b00)) === 1'b1) begin
      a = mkEv(cyc, stack_push, stack_pop, stack_en32, stack_wdata, pc_sel, ret_pc,
               flags_restore, flags_out);
      nVec++;
      if (evQ.size() == 0) begin
        nErr++;
        $display("FAIL strobe_unexpected cyc=%0d got=%h required=none", cyc, a);
      end else begin
        e = evQ.pop_front();
        if (a !== e) begin
          nErr++;
          $display("FAIL strobe cyc=%0d got=%h required=%h", cyc, a, e);
        end
      end
    end
    allOut = {fetch_hold, stack_push, stack_pop, stack_en32, stack_wdata, pc_sel, ret_pc,
              flags_restore, flags_out, int_active};
    while (lvQ.size() > 0 && lvQ[0].c <= cyc) begin
      l = lvQ.pop_front();
      nVec++;
      if (l.c != cyc || fetch_hold !== l.fh || int_active !== l.act ||
          (l.zero && allOut !== '0)) begin
        nErr++;
        $display("FAIL level cyc=%0d want_cyc=%0d got fh=%b act=%b out=%h required fh=%b act=%b zero=%b",
                 cyc, l.c, fetch_hold, int_active, allOut, l.fh, l.act, l.zero);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Entry, return, request during SERVICE, then stalled second entry.
    pc_in = 32'h40; flags_in = 4'hA;
    base = cyc + 1;
    expLv(1, 0, 0, 1);
    expLv(2, 1, 1, 0); expLv(3, 1, 1, 0); expLv(4, 1, 1, 0);
    expEv(5, 1, 0, 1, 32'h40, 2'b00, 0, 0, 0);
    expEv(6, 1, 0, 0, 32'hA, 2'b00, 0, 0, 0);
    expEv(7, 0, 0, 0, 0, 2'b01, 0, 0, 0);
    expLv(7, 0, 1, 0); expLv(8, 0, 1, 0);
    expEv(11, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    expLv(11, 1, 1, 0);
    expEv(12, 0, 1, 1, 0, 2'b00, 0, 1, 4'h5);
    expLv(12, 1, 1, 0);
    expEv(13, 0, 0, 0, 0, 2'b10, 32'h40, 0, 0);
    expLv(13, 0, 1, 0);
    expLv(14, 0, 0, 1);
    expLv(15, 1, 1, 0); expLv(16, 1, 1, 0); expLv(17, 1, 1, 0);
    expLv(18, 1, 1, 0); expLv(19, 1, 1, 0);
    expEv(20, 1, 0, 1, 32'h80, 2'b00, 0, 0, 0);
    expEv(21, 1, 0, 0, 32'h3, 2'b00, 0, 0, 0);
    expEv(22, 0, 0, 0, 0, 2'b01, 0, 0, 0);
    expLv(22, 0, 1, 0);
    int_req = 1'b1;
    goto(3);  pc_in = 32'hDEAD_BEEF; flags_in = 4'h0; int_req = 1'b0;
    goto(8);  int_req = 1'b1; pc_in = 32'h80; flags_in = 4'h3;
    goto(10); rti_dec = 1'b1;
    goto(11); rti_dec = 1'b0;
    goto(12); mem_rdata = 32'h5;
    goto(13); mem_rdata = 32'h40;
    goto(14); mem_rdata = 32'h0; int_req = 1'b0;
    goto(16); stall = 1'b1;
    goto(18); stall = 1'b0;
    goto(24);

    rst = 1'b0; tick(); tick(); rst = 1'b1; tick();

    // Reset asserted while in PUSH_FLAGS.
    pc_in = 32'h100; flags_in = 4'hC;
    base = cyc + 1;
    expLv(2, 1, 1, 0);
    expEv(5, 1, 0, 1, 32'h100, 2'b00, 0, 0, 0);
    expEv(6, 1, 0, 0, 32'hC, 2'b00, 0, 0, 0);
    for (int i = 7; i <= 12; i++) expLv(i, 0, 0, 1);
    int_req = 1'b1;
    goto(6); rst = 1'b0; int_req = 1'b0;
    goto(8); rst = 1'b1;
    goto(13);

    // Stray RTI while idle.
    base = cyc + 1;
    mem_rdata = 32'h77;
    for (int i = 0; i <= 3; i++) expLv(i, 0, 0, 1);
    goto(0); rti_dec = 1'b1;
    goto(1); rti_dec = 1'b0;
    goto(5);

    nVec++;
    if (evQ.size() != 0) begin
      nErr++;
      $display("FAIL events_left got=%0d required=0", evQ.size());
    end
    nVec++;
    if (lvQ.size() != 0) begin
      nErr++;
      $display("FAIL levels_left got=%0d required=0", lvQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
